pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and instruction-fetch sequencer for the single-cycle CPU datapath.
- Drives `pc_plus4` to the branch-target adder and consumes that adder's target.
- Selects the next PC (sequential / branch / j / jr) and fetches from instruction memory over a req/ready handshake.
- Presents one fetched instruction at a time to decode, holding it until the core releases it.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc  output  32  current PC (address of `instr`).
- pc_plus4  output  32  pc + 4, combinational, to the branch adder.
- branch_target  input  32  pc_plus4 + offset, from the branch adder.
- branch_taken  input  1  branch condition true for the current instruction.
- jump  input  1  j/jal for the current instruction.
- jump_index  input  26  instr_index field.
- jr  input  1  jr/jalr for the current instruction.
- jr_addr  input  32  register-file rs value.
- stall  input  1  core not ready to release the current instruction.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, equals pc.
- imem_ready  input  1  imem_rdata valid this cycle.
- imem_rdata  input  32  fetched word.
- instr  output  32  held instruction.
- instr_valid  output  1  instr is valid for decode.
- misalign  output  1  sticky: a selected next PC had bits [1:0] != 0.
- retired  output  CNT_W  count of instructions released.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign=0, retired=0, state=IDLE.
  - pc_plus4 follows pc combinationally, so it reads RESET_PC+4 during reset.
  - Deassertion is taken on the next clk edge.
- FSM states: IDLE, REQ, HOLD, HALT.
- IDLE: one cycle after reset release, then -> REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - If imem_ready=1: instr<=imem_rdata, instr_valid<=1 (visible the next cycle), -> HOLD.
  - Otherwise stay in REQ with req held and addr stable. Ready on the same cycle as the first req is legal, giving minimum fetch latency = 1 cycle.
- HOLD:
  - instr_valid=1, imem_req=0; control inputs are sampled here only.
  - If stall=1: hold pc, instr, and all outputs.
  - If stall=0: compute next PC with priority jr > jump > branch_taken > sequential.
    - jr: next = jr_addr.
    - jump: next = {pc_plus4[31:28], jump_index, 2'b00}.
    - branch_taken: next = branch_target.
    - sequential: next = pc_plus4.
  - On release: retired+=1 and instr_valid<=0.
    - If next[1:0] != 0: misalign<=1, pc unchanged, -> HALT.
    - Otherwise pc<=next, -> REQ.
- HALT: imem_req=0, instr_valid=0, all state frozen until reset.
- Arithmetic:
  - All adds are mod 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0, and wrap is legal.
  - retired wraps at 2^CNT_W.
- Simultaneous events:
  - Multiple control inputs asserted: priority order above, no error.
  - stall=1 during REQ: ignored; stall only matters in HOLD.
  - Control inputs outside HOLD: ignored.
- Reset mid-fetch (REQ with ready pending): immediate return to reset values. A late imem_ready after reset is ignored because the FSM is in IDLE.
- At most one outstanding fetch; imem_addr never changes while imem_req=1.

Test Plan:
- Reset, then imem_ready tied 1, no control, stall=0 -> fetch addresses 0x3000, 0x3004, 0x3008; instr_valid pulses; retired=3 after third release.
- pc=0x3010, branch_taken=1, branch_target=0x3020 in HOLD -> next imem_addr=0x3020; retired+1.
- jr=1, jump=1, branch_taken=1 together, jr_addr=0x3100, jump_index=0x0000C80 -> next pc=0x3100 (jr wins). Repeat with jr=0 -> pc=0x3200.
- imem_ready held low 5 cycles in REQ -> imem_req stays 1, addr stable, instr_valid=0. Ready on cycle 6 with rdata=0x2408_0001 -> instr=0x2408_0001, instr_valid=1 next cycle.
- stall=1 for 3 cycles in HOLD -> pc, instr, and retired unchanged. Release with jr_addr=0x3002 -> misalign=1, HALT, imem_req stays 0; rst_n pulse clears misalign and pc=0x3000.
- Preload via jr_addr=0xFFFF_FFFC -> pc_plus4=0, and the next sequential fetch address=0x0000_0000. Assert rst_n=0 while in REQ -> imem_req drops to 0 asynchronously.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch sequencer: fetches one word at a time over a
// req/ready handshake, holds it for decode, then advances the PC on release.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic [31:0]      branch_target,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [31:0]      jr_addr,
    input  logic             stall,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             misalign,
    output logic [CNT_W-1:0] retired
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic [1:0]  state;
    logic [31:0] next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    // Decoded from state so the request drops the instant reset asserts.
    assign imem_req  = (state == REQ);

    // Next-PC select, priority jr > jump > branch > sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jr)
            next_pc = jr_addr;
        else if (jump)
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        else if (branch_taken)
            next_pc = branch_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        retired     <= retired + CNT_W'(1);
                        instr_valid <= 1'b0;
                        // A misaligned target stops the core with pc left at the faulting instruction.
                        if (next_pc[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= REQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized
// fetch/release traffic compared against a transaction-level PC model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          CNT_W    = 32;

    logic             clk;
    logic             rst_n;
    logic [31:0]      pc, pc_plus4, branch_target, jr_addr, imem_addr, imem_rdata, instr;
    logic             branch_taken, jump, jr, stall, imem_req, imem_ready, instr_valid, misalign;
    logic [25:0]      jump_index;
    logic [CNT_W-1:0] retired;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_pc;
    int unsigned exp_ret;

    pc_fetch_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_plus4(pc_plus4),
        .branch_target(branch_target), .branch_taken(branch_taken),
        .jump(jump), .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .misalign(misalign), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: where the core goes after releasing an instruction at addr p.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic m_jr, m_j, m_br,
                                               input logic [31:0] jra, input logic [25:0] ji,
                                               input logic [31:0] bt);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (m_jr) return jra;
        if (m_j)  return (seq & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
        if (m_br) return bt;
        return seq;
    endfunction

    task automatic clear_inputs();
        branch_target = '0; branch_taken = 0; jump = 0; jump_index = '0;
        jr = 0; jr_addr = '0; stall = 0; imem_ready = 0; imem_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        exp_pc  = RESET_PC;
        exp_ret = 0;
    endtask

    // Waits (bounded) for a request, optionally delays ready, then delivers rdata.
    task automatic do_fetch(input logic [31:0] rdata, input int delay,
                            output logic [31:0] addr, output bit ok);
        ok = 1;
        addr = '0;
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
        if (!imem_req) begin
            ok = 0;
        end else begin
            addr = imem_addr;
            for (int i = 0; i < delay; i++) begin
                imem_ready = 0;
                stall = 1;
                @(negedge clk);
                if (!imem_req || imem_addr !== addr || instr_valid) ok = 0;
            end
            stall = 0;
            imem_ready = 1;
            imem_rdata = rdata;
            @(negedge clk);
            imem_ready = 0;
        end
    endtask

    task automatic do_release(input logic r_jr, r_j, r_br, input logic [31:0] jra,
                              input logic [25:0] ji, input logic [31:0] bt, input int stall_cyc);
        jr = r_jr; jump = r_j; branch_taken = r_br;
        jr_addr = jra; jump_index = ji; branch_target = bt;
        stall = 1;
        repeat (stall_cyc) @(negedge clk);
        stall = 0;
        @(negedge clk);
        jr = 0; jump = 0; branch_taken = 0;
        exp_pc = model_next(exp_pc, r_jr, r_j, r_br, jra, ji, bt);
        exp_ret++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        tests++; if (pc !== RESET_PC) begin fails++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
        tests++; if (pc_plus4 !== RESET_PC + 32'd4) begin fails++; $display("FAIL reset_pc_plus4 got %h want %h", pc_plus4, RESET_PC + 32'd4); end
        tests++; if ({imem_req, instr_valid, misalign} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {imem_req, instr_valid, misalign}); end
        tests++; if (instr !== 32'd0 || retired !== '0) begin fails++; $display("FAIL reset_instr_retired got %h/%0d want 0/0", instr, retired); end
        rst_n = 1;
        exp_pc = RESET_PC; exp_ret = 0;
        @(negedge clk);
        tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin fails++; $display("FAIL first_req got %b@%h want 1@%h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            do_fetch(32'hA000_0000 + k, 0, a, ok);
            tests++; if (!ok || a !== exp_pc) begin fails++; $display("FAIL seq_addr%0d got %h ok=%0d want %h", k, a, ok, exp_pc); end
            tests++; if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 + k) begin fails++; $display("FAIL seq_instr%0d got %b/%h want 1/%h", k, instr_valid, instr, 32'hA000_0000 + k); end
            do_release(0, 0, 0, '0, '0, '0, 0);
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL seq_valid_drop%0d got %b want 0", k, instr_valid); end
        end
        tests++; if (retired !== 3) begin fails++; $display("FAIL seq_retired got %0d want 3", retired); end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h1, 0, a, ok);
        do_release(0, 0, 0, '0, '0, '0, 0);
        do_fetch(32'h1000_0004, 0, a, ok);
        tests++; if (!ok || a !== 32'h3010) begin fails++; $display("FAIL br_pc got %h want 00003010", a); end
        do_release(0, 0, 1, '0, '0, 32'h3020, 0);
        tests++; if (imem_addr !== 32'h3020 || imem_req !== 1'b1) begin fails++; $display("FAIL br_target got %b@%h want 1@00003020", imem_req, imem_addr); end
        tests++; if (retired !== exp_ret) begin fails++; $display("FAIL br_retired got %0d want %0d", retired, exp_ret); end
    endtask

    task automatic test_priority();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h2, 0, a, ok);
        do_release(1, 1, 1, 32'h3100, 26'h0000C80, 32'h3300, 0);
        tests++; if (pc !== 32'h3100) begin fails++; $display("FAIL prio_jr got %h want 00003100", pc); end
        do_fetch(32'h3, 0, a, ok);
        do_release(0, 1, 1, 32'h3100, 26'h0000C80, 32'h3300, 0);
        tests++; if (pc !== 32'h3200) begin fails++; $display("FAIL prio_jump got %h want 00003200", pc); end
    endtask

    task automatic test_ready_wait();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h2408_0001, 5, a, ok);
        tests++; if (!ok || a !== 32'h3200) begin fails++; $display("FAIL wait_stable ok=%0d addr %h want 1/00003200", ok, a); end
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h2408_0001) begin fails++; $display("FAIL wait_instr got %b/%h want 1/24080001", instr_valid, instr); end
    endtask

    // Entered in HOLD with the instruction from test_ready_wait.
    task automatic test_stall_misalign();
        logic [31:0] p0, i0;
        logic [CNT_W-1:0] r0;
        p0 = pc; i0 = instr; r0 = retired;
        stall = 1; jr = 1; jr_addr = 32'h3400;
        repeat (3) begin
            @(negedge clk);
            tests++; if (pc !== p0 || instr !== i0 || retired !== r0 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                fails++; $display("FAIL stall_hold got pc %h instr %h ret %0d v %b req %b", pc, instr, retired, instr_valid, imem_req);
            end
        end
        do_release(1, 0, 0, 32'h3002, '0, '0, 0);
        repeat (3) begin
            tests++; if (misalign !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== p0) begin
                fails++; $display("FAIL halt got mis %b req %b v %b pc %h want 1 0 0 %h", misalign, imem_req, instr_valid, pc, p0);
            end
            @(negedge clk);
        end
        tests++; if (retired !== exp_ret) begin fails++; $display("FAIL halt_retired got %0d want %0d", retired, exp_ret); end
        apply_reset();
        tests++; if (misalign !== 1'b0 || pc !== 32'h3000) begin fails++; $display("FAIL halt_reset got mis %b pc %h want 0 00003000", misalign, pc); end
    endtask

    task automatic test_wrap_and_async_reset();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h5, 0, a, ok);
        do_release(1, 0, 0, 32'hFFFF_FFFC, '0, '0, 0);
        tests++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_pc got %h+4=%h want fffffffc+4=0", imem_addr, pc_plus4); end
        do_fetch(32'h6, 0, a, ok);
        do_release(0, 0, 0, '0, '0, '0, 0);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_seq got %b@%h want 1@00000000", imem_req, imem_addr); end
        #2 rst_n = 0;
        #1;
        tests++; if (imem_req !== 1'b0 || pc !== RESET_PC) begin fails++; $display("FAIL async_reset got req %b pc %h want 0 %h", imem_req, pc, RESET_PC); end
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin fails++; $display("FAIL late_ready got v %b instr %h req %b want 0 0 1", instr_valid, instr, imem_req); end
        imem_ready = 0;
        exp_pc = RESET_PC; exp_ret = 0;
    endtask

    task automatic test_random();
        logic [31:0] a, rd, jra, bt;
        logic [25:0] ji;
        logic r_jr, r_j, r_br;
        bit ok;
        int errs;
        errs = 0;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            rd = $urandom;
            do_fetch(rd, $urandom_range(0, 3), a, ok);
            if (!ok || a !== exp_pc || instr !== rd || instr_valid !== 1'b1) begin
                errs++; $display("FAIL rand_fetch%0d got %h/%h ok=%0d want %h/%h", n, a, instr, ok, exp_pc, rd);
            end
            r_jr = ($urandom_range(0, 3) == 0);
            r_j  = ($urandom_range(0, 2) == 0);
            r_br = $urandom_range(0, 1);
            jra = $urandom & 32'hFFFF_FFFC;
            bt  = $urandom & 32'hFFFF_FFFC;
            ji  = 26'($urandom);
            do_release(r_jr, r_j, r_br, jra, ji, bt, $urandom_range(0, 2));
        end
        tests++; if (errs != 0) begin fails++; $display("FAIL rand_traffic %0d bad fetches, want 0", errs); end
        tests++; if (retired !== exp_ret || misalign !== 1'b0) begin fails++; $display("FAIL rand_retired got %0d mis %b want %0d 0", retired, misalign, exp_ret); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_ready_wait();
        test_stall_misalign();
        test_wrap_and_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
